// File: rtl/imu_sync_buffer_if.sv
// Handshake bundle for imu_sync_buffer: FIFO read side plus the valid/ready sample stream.
// The master modport is the buffer itself; slave is the FIFO/consumer environment.
interface imu_sync_buffer_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_empty;
    logic              fifo_read_en;
    logic [DATA_W-1:0] imu_sync_out;
    logic              valid;
    logic              ready;

    modport master (
        input  fifo_data_out,
        input  fifo_empty,
        input  ready,
        output fifo_read_en,
        output imu_sync_out,
        output valid
    );

    modport slave (
        output fifo_data_out,
        output fifo_empty,
        output ready,
        input  fifo_read_en,
        input  imu_sync_out,
        input  valid
    );
endinterface

// File: rtl/imu_sync_buffer.sv
// Prefetching circular buffer between the IMU synchronizer FIFO and the fusion consumer.
// Statistics counters (sample/stall/drop) are built only when IMU_BUF_STATS_EN is defined.
module imu_sync_buffer #(
    parameter int DATA_W      = 64,
    parameter int FIFO_RD_LAT = 0,
    parameter int BUF_DEPTH   = 2,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    imu_sync_buffer_if.master bus
`ifdef IMU_BUF_STATS_EN
    ,
    output logic [CNT_W-1:0]  sample_count,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  drop_count
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int LVL_W = OCC_W + 1;

    generate
        if (FIFO_RD_LAT != 0 && FIFO_RD_LAT != 1) begin : g_bad_lat
            $error("imu_sync_buffer: FIFO_RD_LAT must be 0 or 1");
        end
        if (BUF_DEPTH < FIFO_RD_LAT + 1) begin : g_bad_depth
            $error("imu_sync_buffer: BUF_DEPTH must be at least FIFO_RD_LAT+1");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("imu_sync_buffer: CNT_W must be positive");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              infl_q, infl_d;
    logic              valid_q, valid_d;
    logic              pop;
    logic              rd_en;
    logic              wr_en;
    logic [LVL_W-1:0]  level;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // level counts committed slots after this cycle's pop, so a pop frees room for a same-cycle read
    always_comb begin
        pop   = valid_q && bus.ready;
        level = LVL_W'(occ_q) + LVL_W'(infl_q) - LVL_W'(pop);
        rd_en = !bus.fifo_empty && !flush && !rst && (level < LVL_W'(BUF_DEPTH));
        wr_en = (FIFO_RD_LAT == 0) ? rd_en : (infl_q && !flush && !rst);
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        infl_d = 1'b0;
        if (flush) begin
            // the returning in-flight word is simply not written, and no new read is issued
            head_d = tail_q;
            occ_d  = '0;
        end else begin
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (wr_en) begin
                tail_d = ptr_inc(tail_q);
            end
            occ_d  = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
            infl_d = (FIFO_RD_LAT != 0) && rd_en;
        end
        valid_d = (occ_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            infl_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            infl_q  <= infl_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q] <= bus.fifo_data_out;
        end
    end

    assign bus.fifo_read_en = rd_en;
    assign bus.valid        = valid_q;
    assign bus.imu_sync_out = valid_q ? mem_q[head_q] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && !pop && (occ_q == OCC_W'(BUF_DEPTH))));

`ifdef IMU_BUF_STATS_EN
    logic [CNT_W-1:0] sample_q, stall_q, drop_q;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // at flush, level is exactly what gets discarded: occupancy plus in-flight, minus a completing pop
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
            stall_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (pop) begin
                sample_q <= sat_add(sample_q, CNT_W'(1));
            end
            if (valid_q && !bus.ready) begin
                stall_q <= sat_add(stall_q, CNT_W'(1));
            end
            if (flush) begin
                drop_q <= sat_add(drop_q, CNT_W'(level));
            end
        end
    end

    assign sample_count = sample_q;
    assign stall_count  = stall_q;
    assign drop_count   = drop_q;
`endif

endmodule

// File: tb/tb_imu_sync_buffer.sv
// Bench for imu_sync_buffer: a FIFO_RD_LAT=0 and a FIFO_RD_LAT=1 instance share stimulus,
// each checked against a stream-index model of the FIFO words it should deliver.
module tb_imu_sync_buffer;
    localparam int DW    = 32;
    localparam int D     = 2;
    localparam int CW    = 32;
    localparam int SRC_N = 4096;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    imu_sync_buffer_if #(.DATA_W(DW)) bus0 ();
    imu_sync_buffer_if #(.DATA_W(DW)) bus1 ();

`ifdef IMU_BUF_STATS_EN
    logic [CW-1:0] samp0, stall0, drop0, samp1, stall1, drop1;
    logic [CW-1:0] obs_samp [2];
    logic [CW-1:0] obs_stall [2];
    logic [CW-1:0] obs_drop [2];
`endif

    imu_sync_buffer #(.DATA_W(DW), .FIFO_RD_LAT(0), .BUF_DEPTH(D), .CNT_W(CW)) u_lat0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus0)
`ifdef IMU_BUF_STATS_EN
        ,
        .sample_count (samp0),
        .stall_count  (stall0),
        .drop_count   (drop0)
`endif
    );

    imu_sync_buffer #(.DATA_W(DW), .FIFO_RD_LAT(1), .BUF_DEPTH(D), .CNT_W(CW)) u_lat1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus1)
`ifdef IMU_BUF_STATS_EN
        ,
        .sample_count (samp1),
        .stall_count  (stall1),
        .drop_count   (drop1)
`endif
    );

    // FIFO word stream shared by both instances; each keeps its own read index
    logic [DW-1:0] src [SRC_N];
    int            src_wr;
    int            m_rd [2];
    int            m_occ [2];
    int            m_infl [2];
    int            m_samp [2];
    int            m_stall [2];
    int            m_drop [2];
    int            n_checks;
    int            n_errors;
    logic          obs_valid [2];
    logic          obs_rd [2];
    logic [DW-1:0] obs_out [2];

    typedef struct {
        bit            ready;
        int            push;
        bit            e_valid;
        logic [DW-1:0] e_out;
        bit            e_rd;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] src_at(input int k);
        return (k >= 0 && k < src_wr) ? src[12'(k)] : '0;
    endfunction

    task automatic drive_fifo();
        bus0.fifo_empty    = (m_rd[0] >= src_wr);
        bus0.fifo_data_out = src_at(m_rd[0]);
        bus1.fifo_empty    = (m_rd[1] >= src_wr);
        bus1.fifo_data_out = src_at(m_rd[1] - 1);
    endtask

    task automatic model_cycle(input int i, input bit rdy, input bit fl, input bit rs);
        bit            e_valid;
        bit            pop;
        bit            e_rd;
        bit            wr;
        logic [DW-1:0] e_out;
        string         tag;
        tag     = (i == 0) ? "lat0" : "lat1";
        e_valid = (m_occ[i] > 0);
        e_out   = e_valid ? src_at(m_rd[i] - m_infl[i] - m_occ[i]) : '0;
        pop     = e_valid && rdy;
        e_rd    = (m_rd[i] < src_wr) && !fl && !rs && (m_occ[i] + m_infl[i] - int'(pop) < D);
        chk({tag, " valid"}, 64'(obs_valid[i]), 64'(e_valid));
        chk({tag, " data"}, 64'(obs_out[i]), 64'(e_out));
        chk({tag, " rd_en"}, 64'(obs_rd[i]), 64'(e_rd));
`ifdef IMU_BUF_STATS_EN
        chk({tag, " sample_count"}, 64'(obs_samp[i]), 64'(m_samp[i]));
        chk({tag, " stall_count"}, 64'(obs_stall[i]), 64'(m_stall[i]));
        chk({tag, " drop_count"}, 64'(obs_drop[i]), 64'(m_drop[i]));
`endif
        if (rs) begin
            m_occ[i]   = 0;
            m_infl[i]  = 0;
            m_samp[i]  = 0;
            m_stall[i] = 0;
            m_drop[i]  = 0;
        end else begin
            if (pop) m_samp[i]++;
            if (e_valid && !rdy) m_stall[i]++;
            if (fl) begin
                m_drop[i] += m_occ[i] + m_infl[i] - int'(pop);
                m_occ[i]   = 0;
                m_infl[i]  = 0;
            end else begin
                wr        = (i == 0) ? e_rd : (m_infl[i] != 0);
                m_occ[i]  = m_occ[i] + int'(wr) - int'(pop);
                m_infl[i] = (i == 1) ? int'(e_rd) : 0;
            end
        end
        if (e_rd) m_rd[i]++;
    endtask

    // one clock cycle, entered and left at the falling edge
    task automatic step(input bit r_ready, input bit r_flush, input bit r_rst, input int r_push);
        if (src_wr + r_push <= SRC_N) src_wr += r_push;
        rst         = r_rst;
        flush       = r_flush;
        bus0.ready  = r_ready;
        bus1.ready  = r_ready;
        drive_fifo();
        #1;
        obs_valid[0] = bus0.valid;
        obs_out[0]   = bus0.imu_sync_out;
        obs_rd[0]    = bus0.fifo_read_en;
        obs_valid[1] = bus1.valid;
        obs_out[1]   = bus1.imu_sync_out;
        obs_rd[1]    = bus1.fifo_read_en;
`ifdef IMU_BUF_STATS_EN
        obs_samp[0]  = samp0;
        obs_stall[0] = stall0;
        obs_drop[0]  = drop0;
        obs_samp[1]  = samp1;
        obs_stall[1] = stall1;
        obs_drop[1]  = drop1;
`endif
        for (int i = 0; i < 2; i++) model_cycle(i, r_ready, r_flush, r_rst);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int p;
        int pulses0;
        int pulses1;
        n_checks = 0;
        n_errors = 0;
        src_wr   = 0;
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 0; m_occ[i] = 0; m_infl[i] = 0;
            m_samp[i] = 0; m_stall[i] = 0; m_drop[i] = 0;
        end
        for (int k = 0; k < SRC_N; k++) src[12'(k)] = (k < 64) ? DW'(k + 1) : DW'($urandom);

        tbl[0] = '{1'b0, 4, 1'b0, 32'd0,  1'b1};
        tbl[1] = '{1'b1, 0, 1'b1, 32'd9,  1'b1};
        tbl[2] = '{1'b0, 0, 1'b1, 32'd10, 1'b1};
        tbl[3] = '{1'b1, 0, 1'b1, 32'd10, 1'b1};
        tbl[4] = '{1'b0, 0, 1'b1, 32'd11, 1'b0};
        tbl[5] = '{1'b1, 0, 1'b1, 32'd11, 1'b0};
        tbl[6] = '{1'b0, 0, 1'b1, 32'd12, 1'b0};
        tbl[7] = '{1'b1, 0, 1'b1, 32'd12, 1'b0};
        tbl[8] = '{1'b0, 0, 1'b0, 32'd0,  1'b0};

        rst = 1'b1; flush = 1'b0; bus0.ready = 1'b0; bus1.ready = 1'b0;
        drive_fifo();
        repeat (2) @(negedge clk);
        step(0, 0, 1, 0);

        // 0x1..0x8 preloaded, ready high: lat0 valid from cycle 1, lat1 from cycle 2
        for (int c = 0; c < 12; c++) begin
            step(1, 0, 0, (c == 0) ? 8 : 0);
            chk("s1 lat0 valid", 64'(obs_valid[0]), 64'(c >= 1 && c <= 8));
            chk("s1 lat0 data", 64'(obs_out[0]), 64'((c >= 1 && c <= 8) ? c : 0));
            chk("s1 lat1 valid", 64'(obs_valid[1]), 64'(c >= 2 && c <= 9));
            chk("s1 lat1 data", 64'(obs_out[1]), 64'((c >= 2 && c <= 9) ? c - 1 : 0));
        end
`ifdef IMU_BUF_STATS_EN
        chk("s1 lat1 sample_count", 64'(samp1), 64'd8);
        chk("s1 lat0 sample_count", 64'(samp0), 64'd8);
`endif

        // toggling ready on lat0, words 9..12
        for (int r = 0; r < 9; r++) begin
            step(tbl[r].ready, 0, 0, tbl[r].push);
            chk($sformatf("tbl%0d lat0 valid", r), 64'(obs_valid[0]), 64'(tbl[r].e_valid));
            chk($sformatf("tbl%0d lat0 data", r), 64'(obs_out[0]), 64'(tbl[r].e_out));
            chk($sformatf("tbl%0d lat0 rd_en", r), 64'(obs_rd[0]), 64'(tbl[r].e_rd));
        end
`ifdef IMU_BUF_STATS_EN
        chk("tbl lat0 stall_count", 64'(stall0), 64'd3);
`endif
        repeat (6) step(1, 0, 0, 0);

        // backpressure: six words queued, ready low for ten cycles
        pulses0 = 0;
        pulses1 = 0;
        for (int c = 0; c < 10; c++) begin
            step(0, 0, 0, (c == 0) ? 6 : 0);
            pulses0 += int'(obs_rd[0]);
            pulses1 += int'(obs_rd[1]);
        end
        chk("bp lat0 read pulses", 64'(pulses0), 64'(D));
        chk("bp lat1 read pulses", 64'(pulses1), 64'(D));
        chk("bp lat0 valid held", 64'(obs_valid[0]), 64'd1);
        chk("bp lat1 valid held", 64'(obs_valid[1]), 64'd1);
        repeat (12) step(1, 0, 0, 0);

        // flush with lat1 holding one word and one read in flight
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        p = src_wr;
        step(0, 1, 0, 1);
        step(1, 0, 0, 0);
        chk("flush lat0 valid low", 64'(obs_valid[0]), 64'd0);
        chk("flush lat1 valid low", 64'(obs_valid[1]), 64'd0);
        chk("flush lat0 read resumes", 64'(obs_rd[0]), 64'd1);
        chk("flush lat1 read resumes", 64'(obs_rd[1]), 64'd1);
`ifdef IMU_BUF_STATS_EN
        chk("flush lat0 drop_count", 64'(drop0), 64'd2);
        chk("flush lat1 drop_count", 64'(drop1), 64'd2);
`endif
        step(1, 0, 0, 0);
        chk("flush lat0 next word", 64'(obs_out[0]), 64'(src[12'(p)]));
        step(1, 0, 0, 0);
        chk("flush lat1 next word", 64'(obs_out[1]), 64'(src[12'(p)]));
        repeat (4) step(1, 0, 0, 0);

        // reset mid-stream with a full buffer
        p = src_wr;
        step(0, 0, 0, 4);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("rst lat0 valid", 64'(obs_valid[0]), 64'd0);
        chk("rst lat0 data", 64'(obs_out[0]), 64'd0);
        chk("rst lat0 rd_en", 64'(obs_rd[0]), 64'd0);
        chk("rst lat1 valid", 64'(obs_valid[1]), 64'd0);
        chk("rst lat1 rd_en", 64'(obs_rd[1]), 64'd0);
`ifdef IMU_BUF_STATS_EN
        chk("rst lat0 counters", 64'(samp0 | stall0 | drop0), 64'd0);
        chk("rst lat1 counters", 64'(samp1 | stall1 | drop1), 64'd0);
`endif
        step(1, 0, 0, 0);
        chk("rst release lat0 rd_en", 64'(obs_rd[0]), 64'd1);
        chk("rst release lat1 rd_en", 64'(obs_rd[1]), 64'd1);
        step(1, 0, 0, 0);
        chk("rst restart lat0 data", 64'(obs_out[0]), 64'(src[12'(p + 2)]));
        repeat (4) step(1, 0, 0, 0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 199) < 1,
                 ($urandom_range(0, 99) < 40) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
